// File: rtl/regfile_sb_pkg.sv
// Shared constants for the regfile_sb register file and its write-pending scoreboard.
package regfile_sb_pkg;

    localparam int RfDataW = 32;

    localparam logic RstEnable   = 1'b0;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam logic [RfDataW-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set when a producer issues, cleared at writeback, wiped by flush.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    logic [(1<<ADDR_W)-1:0] busy;
    logic [(1<<ADDR_W)-1:0] busy_next;

    // Issue is applied after writeback clears so a new producer stays outstanding;
    // flush is last so it also drops a same-cycle issue.
    always_comb begin
        busy_next = busy;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] == WriteEnable) begin
                busy_next[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write-to-read bypass and built-in busy scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = RfDataW,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] ZeroData = DATA_W'(ZeroWord);

    logic [DATA_W-1:0] regs [DEPTH];

    // Ports are committed in ascending order so the highest-index port's write lands last.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[ADDR_W'(k)] <= ZeroData;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] == WriteEnable &&
                    !(ZERO_REG != 0 && waddr[i*ADDR_W +: ADDR_W] == '0)) begin
                    regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    genvar j;
    generate
        for (j = 0; j < NUM_RD; j++) begin : g_read
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;
            logic              rv;
            logic              hit;
            logic [DATA_W-1:0] fwd;

            assign ra = raddr[j*ADDR_W +: ADDR_W];

            // A matching write this cycle is the final value, so it overrides both the
            // array contents and any pending busy mark.
            always_comb begin
                hit = 1'b0;
                fwd = ZeroData;
                for (int i = 0; i < NUM_WR; i++) begin
                    if (we[i] == WriteEnable && waddr[i*ADDR_W +: ADDR_W] == ra) begin
                        hit = 1'b1;
                        fwd = wdata[i*DATA_W +: DATA_W];
                    end
                end

                rd = ZeroData;
                rv = 1'b1;
                if (rst == RstEnable) begin
                    rd = ZeroData;
                    rv = 1'b0;
                end else if (re[j] != ReadEnable || (ZERO_REG != 0 && ra == '0)) begin
                    rd = ZeroData;
                    rv = 1'b1;
                end else if (hit) begin
                    rd = fwd;
                    rv = 1'b1;
                end else begin
                    rd = regs[ra];
                    rv = !busy_vec[ra];
                end
            end

            assign rdata[j*DATA_W +: DATA_W] = rd;
            assign rvalid[j]                 = rv;
        end
    endgenerate

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with a built-in write-pending scoreboard. It is the next generation of the single-write, dual-read register file in the ID/WB path. It adds:
- configurable width, depth and read/write port counts;
- same-cycle write-to-read bypass on every port;
- per-register busy bits, set at issue and cleared at writeback, so decode can stall on in-flight results without an external scoreboard.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width; depth = 2^ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports; higher index has priority
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- we  in  NUM_WR  write enable per port
- waddr  in  NUM_WR*ADDR_W  write address, port i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, packed as waddr
- re  in  NUM_RD  read enable per port
- raddr  in  NUM_RD*ADDR_W  read address, packed
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rvalid  out  NUM_RD  read data is final (not awaiting a writeback)
- iss_valid  in  1  an instruction with destination iss_addr issues this cycle
- iss_addr  in  ADDR_W  destination register of issuing instruction
- flush  in  1  pipeline flush; drop all pending marks
- busy_vec  out  2^ADDR_W  registered busy bit per register

## Operation
- Reset (rst==0 at a clk edge): all registers := 0; all busy bits := 0.
- While rst==0, rdata = 0 and rvalid = 0 on every port.
- Write, per port i with we[i]: regs[waddr_i] := wdata_i at the clk edge.
  - With ZERO_REG, address 0 is ignored.
  - Same address on several ports: the highest index wins.
- Read port j:
  - re_j==0, or address 0 with ZERO_REG: rdata_j = 0, rvalid_j = 1.
  - Otherwise, if any write port hits raddr_j with we set: the highest-index hitting wdata is forwarded, rvalid_j = 1.
  - Otherwise: rdata_j = regs[raddr_j], rvalid_j = !busy[raddr_j].
- Busy next-state, evaluated in this order each cycle:
  1. start from current busy;
  2. clear busy[waddr_i] for every we[i];
  3. if iss_valid, set busy[iss_addr] (issue beats writeback on the same address);
  4. if flush, clear all bits, including a same-cycle issue.
- With ZERO_REG, busy[0] is always 0.
- flush does not block writes; data still commits.
- busy_vec is a direct copy of the busy register.

## Timing
- Write latency: data is in the array 1 cycle after we; it is visible in the same cycle through the bypass.
- Read latency: 0 cycles, combinational from raddr, re, we, waddr, wdata and state.
- Issue at cycle t: busy visible from t+1. A read of the same register at t is not blocked by that issue.
- Writeback at cycle t clears busy at t+1. A read at t is already valid through the bypass.
- Issue and writeback on the same address in the same cycle: busy stays 1, because the new producer is outstanding.
- Reset mid-operation: all state is zero at the next edge; in-flight issues are forgotten.
- Combinational depth: NUM_WR comparators plus a priority mux per read port. There is no read-to-write loop.

## Structure
- Shared defines/package holds:
  - reset level constant: RstEnable = 1'b0 for this block;
  - enable constants WriteEnable / ReadEnable;
  - ZeroWord, sized by DATA_W.
- One sub-module, regfile_scoreboard. It owns the busy register, issue/clear/flush priority and busy_vec. It takes the write-port vectors and the issue inputs.
- The top level holds the storage array, write priority logic and the per-read-port bypass mux, generated over NUM_RD.

## Test plan
- Reset: hold rst=0 for 2 cycles, then release. Read x1..x31 → rdata=0, rvalid=1; busy_vec=0.
- Write and bypass: we[0]=1, waddr=5, wdata=0xDEADBEEF, same-cycle raddr[0]=5. Expect rdata=0xDEADBEEF at cycle t. At t+1, with we=0, expect rdata=0xDEADBEEF.
- Port priority: both ports write x7, port0 data 0x11 and port1 data 0x22. Expect same-cycle rdata 0x22 and array value 0x22 afterwards.
- Scoreboard: issue x3 at t. Expect busy_vec[3]=1 and read x3 rvalid=0 at t+1. Write x3=0x55 at t+2: rvalid=1 with 0x55 at t+2, busy cleared at t+3.
- Collision and flush:
  - issue x4 together with a writeback to x4 → busy[4] stays 1;
  - flush with iss_addr=9 → busy_vec=0 next cycle.
- Zero register: write x0=0xFFFF and issue x0 → rdata=0, busy[0]=0, rvalid=1.
